// File: rtl/ram_pkg.sv
// Shared constants for param_ram: FSM state encoding and default geometry.
package ram_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/param_ram.sv
// Single-port byte-writable RAM with registered read data and a
// whole-array zero-fill sequencer (on request and optionally after reset).
module param_ram
    import ram_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cen,
    input  logic                wen,
    input  logic [ADDR_W-1:0]   s_addr,
    input  logic [DATA_W-1:0]   s_din,
    input  logic [DATA_W/8-1:0] s_be,
    input  logic                clr,
    output logic [DATA_W-1:0]   s_dout,
    output logic                s_rvalid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic INIT_CLEAR = (CLEAR_ON_RESET != 0);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              init_pend;
    logic [DATA_W-1:0] mem [DEPTH];

    logic idle_st, start_clr, acc_wr, acc_rd;

    // A clear request (or the pending post-reset fill) pre-empts any access
    // presented in the same cycle.
    assign idle_st   = (state == ST_IDLE);
    assign start_clr = idle_st && (clr || init_pend);
    assign acc_wr    = idle_st && !start_clr && cen && wen;
    assign acc_rd    = idle_st && !start_clr && cen && !wen;
    assign busy      = (state == ST_CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            clr_ptr   <= '0;
            init_pend <= INIT_CLEAR;
        end else begin
            init_pend <= 1'b0;
            if (state == ST_IDLE) begin
                if (start_clr) begin
                    state   <= ST_CLEAR;
                    clr_ptr <= '0;
                end
            end else begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
                if (clr_ptr == ADDR_W'(DEPTH - 1))
                    state <= ST_IDLE;
            end
        end
    end

    // Array contents survive reset; only the CLEAR state zeroes them.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (acc_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (s_be[i])
                    mem[s_addr][8*i +: 8] <= s_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_dout   <= '0;
            s_rvalid <= 1'b0;
        end else begin
            s_dout   <= acc_rd ? mem[s_addr] : '0;
            s_rvalid <= acc_rd;
        end
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 64: word width in bits; multiple of 8.
REQ-002 Parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 runs a full zero-fill after reset release; 0 skips it.
REQ-004 One clock, rising edge; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 cen  input  1  chip enable; an access occurs only when 1.
REQ-008 wen  input  1  1 = write, 0 = read, qualified by cen.
REQ-009 s_addr  input  ADDR_W  word address.
REQ-010 s_din  input  DATA_W  write data.
REQ-011 s_be  input  DATA_W/8  byte write enables; bit i covers s_din[8i+7:8i].
REQ-012 clr  input  1  single-cycle request to zero-fill the whole array.
REQ-013 s_dout  output  DATA_W  registered read data.
REQ-014 s_rvalid  output  1  high for one cycle when s_dout carries read data.
REQ-015 busy  output  1  high while a zero-fill is in progress.

Function
REQ-016 FSM states: IDLE and CLEAR; CLEAR holds a word counter clr_ptr of ADDR_W bits.
REQ-017 IDLE -> CLEAR on clr=1, or on the first edge after reset release when CLEAR_ON_RESET=1; clr_ptr loads 0.
REQ-018 In CLEAR, the block writes mem[clr_ptr] <= 0 every cycle and increments clr_ptr; after writing DEPTH-1 it returns to IDLE, so a clear takes exactly DEPTH cycles.
REQ-019 busy = 1 exactly while the state is CLEAR.
REQ-020 While busy=1, cen/wen/s_addr/s_din/s_be are ignored: no write, s_rvalid=0, s_dout=0.
REQ-021 clr asserted while already in CLEAR is ignored; the clear does not restart.
REQ-022 Write (IDLE, cen=1, wen=1): on the edge, bytes of mem[s_addr] with s_be bit=1 take s_din; other bytes keep their value; s_rvalid=0.
REQ-023 Write side effect: on a write cycle s_dout <= 0.
REQ-024 Read (IDLE, cen=1, wen=0): on the edge, s_dout <= mem[s_addr] and s_rvalid <= 1; read latency is 1 cycle.
REQ-025 Idle access (cen=0): on the edge, s_dout <= 0 and s_rvalid <= 0.
REQ-026 Read-after-write to the same address on consecutive cycles returns the newly written data.
REQ-027 clr and an access in the same IDLE cycle: clr wins; the access is discarded and the state enters CLEAR.
REQ-028 s_addr covers exactly DEPTH words; no out-of-range case exists.

Reset
REQ-029 reset_n=0 asynchronously forces s_dout=0, s_rvalid=0, busy=0, state=IDLE and clr_ptr=0.
REQ-030 Reset does not itself alter memory contents; zero-fill is done only by the CLEAR state.
REQ-031 Reset asserted mid-CLEAR aborts the fill immediately. With CLEAR_ON_RESET=1, a new fill starts at word 0 after release.

Structure
REQ-032 Shared package ram_pkg holds the FSM state encoding (IDLE=0, CLEAR=1) and the default DATA_W/ADDR_W constants.
REQ-033 Single module; the memory array is inferred as a register array with per-byte write enables; no sub-module.

Verification (DATA_W=64, ADDR_W=8, CLEAR_ON_RESET=1)
REQ-034 Release reset -> busy=1 for exactly 256 cycles, then 0; reading addr 8'h55 afterwards -> s_dout=64'h0, s_rvalid=1 one cycle later.
REQ-035 Write 8'haa=64'h1 and 8'hbb=64'h2 with s_be=8'hFF, then read 8'haa and 8'hbb -> s_dout=64'h1 then 64'h2 at 1-cycle latency; then cen=0 -> s_dout=0, s_rvalid=0.
REQ-036 Write 8'h10=64'hFFFF_FFFF_FFFF_FFFF with s_be=8'hFF, then 64'h0 with s_be=8'h0F; read 8'h10 -> 64'hFFFF_FFFF_0000_0000.
REQ-037 Write 8'h20=64'hA5 followed immediately by a read of 8'h20 -> s_dout=64'hA5.
REQ-038 Pulse clr with a simultaneous write to 8'h30; a write attempted mid-clear is ignored -> busy=1 for 256 cycles, and afterwards 8'h30, 8'haa and 8'hbb all read 0.
REQ-039 Assert reset_n=0 at cycle 100 of a clear -> s_dout, s_rvalid and busy drop immediately; after release, busy=1 for a full 256 cycles.
